// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Single-ported memory bus between the arbiter and the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Sequences fetch then data access on one memory port and
//               pulses data_ready_mem once per pipeline step.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        core_start,
    input  wire logic        core_end,
    input  wire logic [31:0] pc_if,
    input  wire logic        memread_mem,
    input  wire logic        memwrite_mem,
    input  wire logic [31:0] alu_result_mem,
    input  wire logic [31:0] write_data_memory_mem,
    mem_port_arbiter_if.master mem,
    output logic [31:0]      instruction_if,
    output logic [31:0]      data_from_memory_mem,
    output logic             data_ready_mem,
    output logic             err_timeout,
    output logic [31:0]      step_count
);

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_tmo_cnt;
    logic [31:0] r_instruction;
    logic [31:0] r_data;
    logic [31:0] r_step_count;
    logic        r_err_timeout;

    logic        w_access;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata;
    logic        w_run;

    always_comb begin
        w_access = (r_state == S_FETCH) || (r_state == S_DATA);
        w_timeout = w_access && !mem.mem_ack && (r_tmo_cnt == c_tmo_last);
        w_done = w_access && (mem.mem_ack || w_timeout);
        // A timed-out access completes with zero data
        w_rdata = mem.mem_ack ? mem.mem_rdata : 32'd0;
        w_run = core_start && !core_end;
    end

    always_comb begin
        w_next        = r_state;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_run) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc_if;
                if (w_done) w_next = (memread_mem || memwrite_mem) ? S_DATA : S_STEP;
            end
            S_DATA: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = memwrite_mem;
                mem.mem_addr  = alu_result_mem;
                mem.mem_wdata = write_data_memory_mem;
                if (w_done) w_next = S_STEP;
            end
            S_STEP: begin
                w_next = w_run ? S_FETCH : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_tmo_cnt     <= 16'd0;
            r_instruction <= 32'd0;
            r_data        <= 32'd0;
            r_step_count  <= 32'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter is zero whenever an access phase is entered
            if (w_access && !w_done) r_tmo_cnt <= r_tmo_cnt + 16'd1;
            else                     r_tmo_cnt <= 16'd0;
            if (w_timeout) r_err_timeout <= 1'b1;
            if ((r_state == S_FETCH) && w_done) r_instruction <= w_rdata;
            if ((r_state == S_DATA) && w_done && !memwrite_mem) r_data <= w_rdata;
            if (r_state == S_STEP) r_step_count <= r_step_count + 32'd1;
        end
    end

    assign instruction_if       = r_instruction;
    assign data_from_memory_mem = r_data;
    assign data_ready_mem       = (r_state == S_STEP);
    assign err_timeout          = r_err_timeout;
    assign step_count           = r_step_count;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-ported instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage core. For every pipeline step it performs the fetch, then the data access if one is pending, and then pulses `data_ready_mem` for one cycle so that the PC and all pipeline registers advance together. It sits between the core and the memory wrapper, and it also gates core execution on `core_start` and `core_end`.

## Interface
- `TIMEOUT`, default 256: maximum number of cycles spent waiting for `mem_ack` in one access before it is forced complete. Range 2..65535.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `core_start` in 1: the core may run while this is high.
- `core_end` in 1: requests a halt; the block finishes the current step and then stops.
- `pc_if` in 32: fetch address.
- `memread_mem`, `memwrite_mem` in 1: MEM-stage access request.
- `alu_result_mem` in 32: data address.
- `write_data_memory_mem` in 32: store data.
- `instruction_if` out 32: latched fetched instruction.
- `data_from_memory_mem` out 32: latched load data.
- `data_ready_mem` out 1: one-cycle pipeline advance strobe.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid when `mem_ack` is high.
- `mem_ack` in 1: access complete. It may be asserted in the same cycle as `mem_req`.
- `err_timeout` out 1: sticky flag, set when any access times out.
- `step_count` out 32: number of completed pipeline steps.

## Operation
- **FSM states:** IDLE, FETCH, DATA, STEP. The state is registered. The memory outputs are combinational from the state and the inputs.
- **IDLE**
  - `mem_req`=0.
  - Moves to FETCH when `core_start`=1 and `core_end`=0.
- **FETCH**
  - `mem_req`=1, `mem_we`=0, `mem_addr`=`pc_if`.
  - On ack: `instruction_if` <= `mem_rdata`.
  - Next state is DATA if `memread_mem`|`memwrite_mem`, otherwise STEP.
- **DATA**
  - `mem_req`=1, `mem_addr`=`alu_result_mem`, `mem_we`=`memwrite_mem`, `mem_wdata`=`write_data_memory_mem`.
  - On ack with `memwrite_mem`=0: `data_from_memory_mem` <= `mem_rdata`.
  - On ack, next state is STEP.
  - If both read and write are high, the access is a write and `data_from_memory_mem` is not updated.
- **STEP**
  - `data_ready_mem`=1 and `step_count` += 1 (wraps at 2^32).
  - Next state is FETCH if `core_start`=1 and `core_end`=0, otherwise IDLE.
- **Ordering:** the fetch always precedes the data access within a step. A store to the address currently being fetched is therefore seen by the next step's fetch, not by this one.
- **Idle outputs:** outside FETCH and DATA, `mem_we`=0 and `mem_addr`/`mem_wdata`=0. `mem_ack` is ignored in IDLE and STEP.
- **Timeout counter**
  - A 16-bit counter resets to 0 on entry to FETCH or DATA and increments on every cycle without ack.
  - If `mem_ack`=0 while the counter equals TIMEOUT-1, the access is treated as acked with rdata=0 and `err_timeout` is set.
  - `err_timeout` is cleared only by reset.
- **Stability guarantee:** pipeline inputs (`pc_if`, `*_mem`) are stable while `data_ready_mem`=0, because the core stalls on that signal. The block relies on this and does not re-latch addresses.

## Timing
- **Reset values:** state=IDLE, `instruction_if`=0, `data_from_memory_mem`=0, `data_ready_mem`=0, `mem_req`=0, `err_timeout`=0, `step_count`=0.
- **Reset priority:** `rstn`=0 overrides everything, including a pending ack. The cycle after the reset edge has `mem_req`=0.
- **Step latency:** with fetch ack latency Lf and data ack latency Ld (1 = same-cycle ack), one step takes Lf+1 cycles without a data access and Lf+Ld+1 cycles with one. The minimum is 2 cycles per instruction.
- **Pulse width:** `data_ready_mem` is high for exactly one cycle per step and never in two consecutive cycles.
- **Output update timing:** `instruction_if` and `data_from_memory_mem` update on the clock edge where ack is seen, then hold through STEP and until the next ack.
- **core_end / core_start deassertion:** if either changes during FETCH or DATA, the current step still completes with a STEP pulse, then the FSM goes to IDLE.
- **Restart:** `core_start` reasserted in IDLE gives FETCH on the next cycle.

## Test plan
- **Reset:** hold `rstn`=0 for 3 cycles with `mem_ack`=1. Required: all outputs 0 and state IDLE; one cycle after release with `core_start`=1, `mem_req`=1 and `mem_addr`=`pc_if`.
- **ALU-only step:** `pc_if`=0x10, no memread/memwrite, same-cycle ack returning 0x00500093. Required: `instruction_if`=0x00500093, `data_ready_mem` pulse on the 2nd cycle, `step_count`=1.
- **Load step:** `memread_mem`=1, `alu_result_mem`=0x100, fetch ack after 3 cycles, data ack after 2 cycles with 0xDEADBEEF. Required: data phase issues `mem_addr`=0x100 with `mem_we`=0, `data_from_memory_mem`=0xDEADBEEF, pulse on the 6th cycle.
- **Store step:** `memwrite_mem`=1, address 0x20, data 0x12345678. Required: data phase has `mem_we`=1, `mem_addr`=0x20, `mem_wdata`=0x12345678, and `data_from_memory_mem` is unchanged.
- **Timeout:** TIMEOUT=4, never ack during fetch. Required: `instruction_if`=0 after 4 cycles, `err_timeout`=1 and sticky, and the step still completes.
- **Halt and mid-access reset:** raise `core_end` mid-DATA; required: one STEP pulse, then IDLE with `mem_req`=0. Separately, pulse `rstn` low mid-FETCH; required: IDLE, `step_count`=0, no `data_ready_mem` pulse.
